subtrator_serial: RTL and testbench

SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

---
 rtl/subtrator_serial_if.sv | 25 ++
 rtl/subtrator_serial.sv | 111 +++++++++++
 tb/tb_subtrator_serial.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/subtrator_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface subtrator_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side: consumes operands, produces status and result.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per clock.

// 1-bit full-subtractor cell.
module subtrator_serial_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  // Difference bit and borrow-out.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (~a & b) | (~(a ^ b) & cin);
  end
endmodule

module subtrator_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  subtrator_serial_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             cell_s;
  logic             cell_cout;

  subtrator_serial_cell u_cell (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (brw),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Control FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            opa   <= bus.a;
            opb   <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa  <= opa >> 1;
          opb  <= opb >> 1;
          diff <= {cell_s, diff[WIDTH-1:1]};
          brw  <= cell_cout;
          cnt  <= cnt + CW'(1);
          // Last bit processed: publish borrow and leave RUN.
          if (cnt == CW'(WIDTH - 1)) begin
            bout  <= cell_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the registered results onto the bus.
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff;
  assign bus.bout = bout;
endmodule

// File: tb/tb_subtrator_serial.sv
// Directed and randomized checks of subtrator_serial against an arithmetic model.
module tb_subtrator_serial;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cycle;

  subtrator_serial_if #(.WIDTH(W)) bus ();

  subtrator_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bi);
    return W'(32'(a) - 32'(b) - 32'(bi));
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, b, input logic bi);
    return (32'(a) < (32'(b) + 32'(bi)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation with a single-cycle start pulse.
  task automatic do_op(input logic [W-1:0] a, b, input logic bi);
    int busy_n;
    bit got;
    busy_n = 0;
    got    = 1'b0;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bi;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.bin = 1'($urandom);
    for (int i = 0; i < int'(W) + 4 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) busy_n++;
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
    chk("diff", 32'(bus.diff), 32'(ref_diff(a, b, bi)));
    chk("bout", 32'(bus.bout), 32'(ref_bout(a, b, bi)));
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("diff_hold", 32'(bus.diff), 32'(ref_diff(a, b, bi)));
    chk("bout_hold", 32'(bus.bout), 32'(ref_bout(a, b, bi)));
  endtask

  initial begin
    logic [W-1:0] ea, eb;
    logic         ebi;
    int           done_cnt;
    int           last_done;
    int           k;

    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.bin     = 1'b0;

    // Reset state.
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start accepted on the first edge after release, then directed corners.
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h80, 8'h01, 1'b1);
    do_op(8'h00, 8'hFF, 1'b1);
    do_op(8'hFF, 8'h00, 1'b1);

    // Start pulse during RUN must be ignored.
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h21; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < int'(W) + 6; i++) begin
      if (bus.done) begin
        done_cnt++;
        chk("ign_diff", 32'(bus.diff), 32'(ref_diff(8'h5A, 8'h21, 1'b1)));
        chk("ign_bout", 32'(bus.bout), 32'(ref_bout(8'h5A, 8'h21, 1'b1)));
      end
      @(negedge clk);
    end
    chk("ign_done_pulses", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of RUN.
    do_op(8'hC3, 8'h42, 1'b1);
    bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_diff", 32'(bus.diff), 32'd0);
    chk("mid_rst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      if (bus.done || bus.busy) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_activity", 32'(done_cnt), 32'd0);
    do_op(8'hF0, 8'h0F, 1'b0);

    // Back-to-back random operations with start held high.
    ea = W'($urandom); eb = W'($urandom); ebi = 1'($urandom);
    bus.a = ea; bus.b = eb; bus.bin = ebi;
    bus.start = 1'b1;
    last_done = 0;
    for (int n = 0; n < 800; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.done && k < 3 * int'(W));
      chk("stream_done_seen", 32'(bus.done), 32'd1);
      chk("stream_diff", 32'(bus.diff), 32'(ref_diff(ea, eb, ebi)));
      chk("stream_bout", 32'(bus.bout), 32'(ref_bout(ea, eb, ebi)));
      if (n > 0) chk("stream_spacing", 32'(cycle - last_done), 32'(W + 2));
      last_done = cycle;
      if (n == 799) bus.start = 1'b0;
      else begin
        ea = W'($urandom); eb = W'($urandom); ebi = 1'($urandom);
        bus.a = ea; bus.b = eb; bus.bin = ebi;
      end
    end
    repeat (3) @(negedge clk);
    chk("stream_end_idle", 32'({bus.busy, bus.done}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
